// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset core.
// Optional shift support (SLL/SRL) is selected with the MIPS_MC_SHIFT_EN macro in mips_mc_core.
package mips_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// Integer register file: two combinational read ports, one synchronous write port.
// r0 always reads as zero and ignores writes.
module mips_mc_regfile
    import mips_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  syn_rst,
    input  logic [ADDR_WIDTH-1:0] ra_addr,
    input  logic [ADDR_WIDTH-1:0] rb_addr,
    output logic [DATA_WIDTH-1:0] ra_data,
    output logic [DATA_WIDTH-1:0] rb_data,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXECUTE/WRITEBACK FSM, ALU, branches, jump, halt.
// Define MIPS_MC_SHIFT_EN to enable R-type SLL/SRL.
//
// state        | meaning
// ST_IDLE      | paused at an instruction boundary, waiting for run
// ST_FETCH     | IR <= instruction at PC
// ST_DECODE    | operands and sign-extended immediate latched
// ST_EXECUTE   | ALU result and equality flag latched
// ST_WRITEBACK | register write, PC update, status pulses
// ST_HALT      | stopped; only syn_rst leaves
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int RF_ADDRESS_WIDTH  = 5,
    parameter int IM_ADDRESS_WIDTH  = 6,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         syn_rst,
    input  logic                         run,
    output logic [IM_ADDRESS_WIDTH-1:0]  imem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0]        result,
    output logic                         result_valid,
    output logic                         busy,
    output logic                         halted,
    output logic                         illegal
);

    if (INSTRUCTION_WIDTH != 32) begin : g_iw_check
        $error("mips_mc_core: INSTRUCTION_WIDTH must be 32");
    end

    state_t state, state_nxt;

    logic [IM_ADDRESS_WIDTH-1:0]  pc, pc_nxt, br_off;
    logic [INSTRUCTION_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0]        a, b, imm, alu_out, alu_res, opnd, result_q;
    logic [DATA_WIDTH-1:0]        rf_a, rf_b;
    logic                         eq;

    logic [5:0]                  opcode, func;
    logic [4:0]                  shamt;
    logic [RF_ADDRESS_WIDTH-1:0] rs, rt, rd, wr_addr;
    alu_op_t                     alu_op;
    logic                        use_imm, wr_en, legal;
    logic                        is_beq, is_bne, is_j, is_halt;
    logic                        wb_we;

    assign opcode = ir[31:26];
    assign func   = ir[5:0];
    assign shamt  = ir[10:6];
    assign rs     = ir[21 +: RF_ADDRESS_WIDTH];
    assign rt     = ir[16 +: RF_ADDRESS_WIDTH];
    assign rd     = ir[11 +: RF_ADDRESS_WIDTH];

    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        wr_en   = 1'b0;
        wr_addr = rd;
        legal   = 1'b1;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        is_halt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wr_en = 1'b1;
                case (func)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_XOR: alu_op = ALU_XOR;
                    FN_SLT: alu_op = ALU_SLT;
`ifdef MIPS_MC_SHIFT_EN
                    FN_SLL: alu_op = ALU_SLL;
                    FN_SRL: alu_op = ALU_SRL;
`endif
                    default: begin
                        wr_en = 1'b0;
                        legal = 1'b0;
                    end
                endcase
                // The all-zero word is the canonical NOP in every build.
                if (ir == '0) begin
                    wr_en = 1'b0;
                    legal = 1'b1;
                end
            end
            OP_ADDI: begin
                use_imm = 1'b1;
                wr_en   = 1'b1;
                wr_addr = rt;
            end
            OP_BEQ:  is_beq  = 1'b1;
            OP_BNE:  is_bne  = 1'b1;
            OP_J:    is_j    = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: legal   = 1'b0;
        endcase
    end

    always_comb begin
        opnd    = use_imm ? imm : b;
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = a + opnd;
            ALU_SUB: alu_res = a - opnd;
            ALU_AND: alu_res = a & opnd;
            ALU_OR:  alu_res = a | opnd;
            ALU_XOR: alu_res = a ^ opnd;
            ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(opnd))};
            ALU_SLL: alu_res = b << shamt;
            ALU_SRL: alu_res = b >> shamt;
            default: alu_res = '0;
        endcase
    end

    assign br_off = IM_ADDRESS_WIDTH'(sext16(ir[15:0]));

    always_comb begin
        pc_nxt = pc + IM_ADDRESS_WIDTH'(1);
        if (is_j) begin
            pc_nxt = ir[IM_ADDRESS_WIDTH-1:0];
        end else if ((is_beq && eq) || (is_bne && !eq)) begin
            pc_nxt = pc + IM_ADDRESS_WIDTH'(1) + br_off;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (run) state_nxt = ST_FETCH;
            ST_FETCH:     state_nxt = ST_DECODE;
            ST_DECODE:    state_nxt = ST_EXECUTE;
            ST_EXECUTE:   state_nxt = ST_WRITEBACK;
            ST_WRITEBACK: state_nxt = is_halt ? ST_HALT : (run ? ST_FETCH : ST_IDLE);
            ST_HALT:      state_nxt = ST_HALT;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    assign wb_we = (state == ST_WRITEBACK) && wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            imm      <= '0;
            alu_out  <= '0;
            eq       <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_FETCH: ir <= imem_rdata;
                ST_DECODE: begin
                    a   <= rf_a;
                    b   <= rf_b;
                    imm <= DATA_WIDTH'(sext16(ir[15:0]));
                end
                ST_EXECUTE: begin
                    alu_out <= alu_res;
                    eq      <= (a == b);
                end
                ST_WRITEBACK: begin
                    if (wb_we) result_q <= alu_out;
                    // PC stays on the HALT word so imem_addr freezes there.
                    if (!is_halt) pc <= pc_nxt;
                end
                default: ;
            endcase
        end
    end

    mips_mc_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (RF_ADDRESS_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .syn_rst (syn_rst),
        .ra_addr (rs),
        .rb_addr (rt),
        .ra_data (rf_a),
        .rb_data (rf_b),
        .we      (wb_we),
        .wa      (wr_addr),
        .wd      (alu_out)
    );

    assign imem_addr    = pc;
    assign result       = wb_we ? alu_out : result_q;
    assign result_valid = wb_we;
    assign busy         = (state == ST_FETCH) || (state == ST_DECODE) ||
                          (state == ST_EXECUTE) || (state == ST_WRITEBACK);
    assign halted       = (state == ST_HALT);
    assign illegal      = (state == ST_WRITEBACK) && !legal;

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core; expectations for SLL/SRL follow MIPS_MC_SHIFT_EN.
module tb_mips_mc_core;

    logic        clk = 1'b0;
    logic        syn_rst;
    logic        run;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic        halted;
    logic        illegal;

    logic [31:0] mem [64];
    int n_cmp  = 0;
    int n_fail = 0;

    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    mips_mc_core dut (
        .clk          (clk),
        .syn_rst      (syn_rst),
        .run          (run),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .halted       (halted),
        .illegal      (illegal)
    );

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int target);
        return {6'h02, 26'(target)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in FETCH; leaves in the next FETCH after checking the WRITEBACK cycle.
    task automatic exec_one(input string tag, input logic exp_valid, input logic [15:0] exp_res,
                            input logic exp_ill, input logic [5:0] exp_pc);
        tick();
        tick();
        check({tag, "_ex_valid"}, 32'(result_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(result_valid), 32'(exp_valid));
        if (exp_valid) check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        tick();
        check({tag, "_pc"}, 32'(imem_addr), 32'(exp_pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = enc_i(6'h08, 0, 1, 5);
        mem[1]  = enc_i(6'h08, 0, 2, -3);
        mem[2]  = enc_r(1, 2, 3, 0, 6'h20);
        mem[3]  = enc_i(6'h04, 1, 1, 2);
        mem[6]  = enc_i(6'h05, 1, 1, 5);
        mem[7]  = enc_r(2, 1, 4, 0, 6'h22);
        mem[8]  = enc_r(2, 1, 5, 0, 6'h2A);
        mem[9]  = enc_r(1, 2, 5, 0, 6'h2A);
        mem[10] = enc_i(6'h08, 0, 6, 16'h7FFF);
        mem[11] = enc_i(6'h08, 0, 7, 1);
        mem[12] = enc_r(6, 7, 8, 0, 6'h20);
        mem[13] = enc_r(1, 2, 9, 0, 6'h24);
        mem[14] = enc_r(1, 2, 9, 0, 6'h25);
        mem[15] = enc_r(1, 2, 10, 0, 6'h26);
        mem[16] = enc_i(6'h08, 0, 0, 7);
        mem[17] = enc_r(0, 0, 11, 0, 6'h20);
        mem[18] = enc_i(6'h11, 0, 0, 0);
        mem[19] = 32'h0000_0000;
        mem[20] = enc_r(0, 1, 6, 2, 6'h00);
        mem[21] = enc_r(0, 1, 12, 17, 6'h02);
        mem[22] = enc_r(6, 0, 13, 0, 6'h20);
        mem[23] = enc_j(63);
        mem[63] = enc_i(6'h04, 1, 1, 1);

        syn_rst = 1'b1;
        run     = 1'b0;
        tick();
        tick();
        syn_rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_pc", 32'(imem_addr), 32'd0);

        run = 1'b1;
        tick();
        check("fetch_busy", 32'(busy), 32'd1);
        exec_one("addi_r1", 1'b1, 16'd5, 1'b0, 6'd1);
        exec_one("addi_r2", 1'b1, 16'hFFFD, 1'b0, 6'd2);
        exec_one("add_r3", 1'b1, 16'd2, 1'b0, 6'd3);
        exec_one("beq_taken", 1'b0, 16'd0, 1'b0, 6'd6);
        exec_one("bne_not_taken", 1'b0, 16'd0, 1'b0, 6'd7);
        exec_one("sub_r4", 1'b1, 16'hFFF8, 1'b0, 6'd8);
        exec_one("slt_true", 1'b1, 16'd1, 1'b0, 6'd9);
        exec_one("slt_false", 1'b1, 16'd0, 1'b0, 6'd10);
        exec_one("addi_7fff", 1'b1, 16'h7FFF, 1'b0, 6'd11);
        exec_one("addi_one", 1'b1, 16'd1, 1'b0, 6'd12);
        exec_one("add_wrap", 1'b1, 16'h8000, 1'b0, 6'd13);
        exec_one("and", 1'b1, 16'h0005, 1'b0, 6'd14);
        exec_one("or", 1'b1, 16'hFFFD, 1'b0, 6'd15);
        exec_one("xor", 1'b1, 16'hFFF8, 1'b0, 6'd16);
        exec_one("addi_r0", 1'b0, 16'd0, 1'b0, 6'd17);
        exec_one("r0_is_zero", 1'b1, 16'd0, 1'b0, 6'd18);
        exec_one("bad_opcode", 1'b0, 16'd0, 1'b1, 6'd19);
        exec_one("nop_word", 1'b0, 16'd0, 1'b0, 6'd20);
`ifdef MIPS_MC_SHIFT_EN
        exec_one("sll", 1'b1, 16'd20, 1'b0, 6'd21);
        exec_one("srl_big", 1'b1, 16'd0, 1'b0, 6'd22);
        exec_one("r6_after", 1'b1, 16'd20, 1'b0, 6'd23);
`else
        exec_one("sll_illegal", 1'b0, 16'd0, 1'b1, 6'd21);
        exec_one("srl_illegal", 1'b0, 16'd0, 1'b1, 6'd22);
        exec_one("r6_after", 1'b1, 16'h7FFF, 1'b0, 6'd23);
`endif
        exec_one("j_63", 1'b0, 16'd0, 1'b0, 6'd63);
        exec_one("beq_wrap", 1'b0, 16'd0, 1'b0, 6'd1);

        // run drops during EXECUTE of the instruction at PC=1
        tick();
        tick();
        run = 1'b0;
        tick();
        check("drop_valid", 32'(result_valid), 32'd1);
        check("drop_result", 32'(result), 32'hFFFD);
        tick();
        check("drop_idle_busy", 32'(busy), 32'd0);
        check("drop_idle_pc", 32'(imem_addr), 32'd2);
        tick();
        tick();
        tick();
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_pc", 32'(imem_addr), 32'd2);
        run = 1'b1;
        tick();
        check("resume_busy", 32'(busy), 32'd1);
        check("resume_pc", 32'(imem_addr), 32'd2);
        exec_one("resume_add", 1'b1, 16'd2, 1'b0, 6'd3);

        // reset during DECODE
        tick();
        syn_rst = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pc", 32'(imem_addr), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_valid", 32'(result_valid), 32'd0);
        check("mid_rst_halted", 32'(halted), 32'd0);
        check("mid_rst_illegal", 32'(illegal), 32'd0);
        run     = 1'b0;
        mem[0]  = enc_r(1, 0, 14, 0, 6'h20);
        mem[1]  = enc_j(10);
        mem[10] = {6'h3F, 26'h0};
        syn_rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        run = 1'b1;
        tick();
        exec_one("r1_cleared", 1'b1, 16'd0, 1'b0, 6'd1);
        exec_one("j_10", 1'b0, 16'd0, 1'b0, 6'd10);

        tick();
        tick();
        tick();
        check("halt_wb_halted", 32'(halted), 32'd0);
        tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_pc", 32'(imem_addr), 32'd10);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_frozen_pc", 32'(imem_addr), 32'd10);
            check("halt_stays", 32'(halted), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
